// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
// Software pushes bytes through TXDATA and polls STATUS to avoid overflowing the FIFO.
module uart_tx_io #(
   parameter int CLK_DIV = 200,
   parameter int FIFO_AW = 2
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        ioread,
   input  logic        iowrite,
   input  logic        uartctrl,
   input  logic [1:0]  address,
   input  logic [31:0] write_data,
   output logic [15:0] ioread_data,
   output logic        tx
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int BW    = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [1:0]         state_q, state_d;
   logic [BW-1:0]      baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;

   logic push_req, push, pop, full, empty, status_rd;
   logic [15:0] status;
   logic unused_wdata;

   assign unused_wdata = ^write_data[31:8];

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign push_req  = iowrite & uartctrl & (address == 2'b00);
   assign push      = push_req & ~full;
   assign status_rd = ioread & uartctrl & (address == 2'b10);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = BAUD_LAST;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_q == '0) begin
               baud_d  = BAUD_LAST;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         S_DATA: begin
            if (baud_q == '0) begin
               baud_d = BAUD_LAST;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
         default: begin
            // Last stop cycle chains straight into the next frame when data is waiting.
            if (baud_q == '0) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  baud_d  = BAUD_LAST;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q - BW'(1);
            end
         end
      endcase
   end

   always_comb begin
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push_req && full) begin
         ovf_d = 1'b1;
      end else if (status_rd) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= write_data[7:0];
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         shift_q  <= 8'h00;
         tx_q     <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   always_comb begin
      status           = '0;
      status[0]        = (state_q != S_IDLE);
      status[1]        = empty;
      status[2]        = full;
      status[3]        = ovf_q;
      status[8 +: CW]  = count_q;
      ioread_data      = status_rd ? status : 16'h0000;
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb/tb_uart_tx_io.sv - self-checking bench for uart_tx_io (CLK_DIV=4, FIFO_AW=2)
// Register vectors from a table, serial frames decoded and matched against a byte scoreboard.
module tb_uart_tx_io;
   localparam int CLK_DIV = 4;
   localparam int FIFO_AW = 2;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        ioread = 1'b0;
   logic        iowrite = 1'b0;
   logic        uartctrl = 1'b0;
   logic [1:0]  address = 2'b00;
   logic [31:0] write_data = 32'h0;
   logic [15:0] ioread_data;
   logic        tx;

   uart_tx_io #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
      .clock(clock), .rst(rst), .ioread(ioread), .iowrite(iowrite),
      .uartctrl(uartctrl), .address(address), .write_data(write_data),
      .ioread_data(ioread_data), .tx(tx)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int passed = 0;
   int total = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        cs;
      logic [1:0]  a;
      logic [7:0]  d;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[13];

   logic [7:0] sb[$];
   int         starts[$];
   bit         mon_en = 1'b0;
   bit         mon_act = 1'b0;
   int         mon_s = 0;
   logic [7:0] mon_sh = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [15:0] st(input logic busy, input logic emp, input logic fl,
                                      input logic ov, input int cnt);
      logic [2:0] c;
      c = 3'(cnt);
      return {5'b0, c, 4'b0, ov, fl, emp, busy};
   endfunction

   function automatic logic exp_tx(input int off, input logic [7:0] b);
      if (off >= 2 && off <= 5) return 1'b0;
      if (off >= 6 && off <= 37) return b[(off - 6) / 4];
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic idle_bus();
      ioread = 0; iowrite = 0; uartctrl = 0; address = 2'b00; write_data = 32'h0;
   endtask

   task automatic drive_write(input logic [7:0] b);
      ioread = 0; iowrite = 1; uartctrl = 1; address = 2'b00; write_data = {24'hA5C3E1, b};
   endtask

   task automatic drive_status_read();
      ioread = 1; iowrite = 0; uartctrl = 1; address = 2'b10; write_data = 32'h0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || mon_act) && n < 2000) begin
         step();
         n++;
      end
      check("drain_scoreboard_empty", sb.size(), 0);
      repeat (4) step();
   endtask

   // Frame decoder: samples each bit in its middle, relative to the first low cycle.
   always @(negedge clock) begin
      if (!mon_en) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_s = cyc;
            starts.push_back(cyc);
         end
      end else begin
         if (cyc - mon_s == 2) check("start_bit", tx, 0);
         if (cyc - mon_s >= 6 && cyc - mon_s <= 34 && ((cyc - mon_s - 6) % 4) == 0)
            mon_sh[(cyc - mon_s - 6) / 4] = tx;
         if (cyc - mon_s == 38) begin
            check("stop_bit", tx, 1);
            if (sb.size() == 0) begin
               total++;
               $display("FAIL frame_byte: got unexpected byte 0x%0h, expected no frame", mon_sh);
            end else begin
               check("frame_byte", mon_sh, sb.pop_front());
            end
            mon_act = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks passed so far", passed);
      $fatal(1);
   end

   initial begin
      int w;
      logic seen_low;

      //           rd wr cs  a      d      exp
      vecs[0]  = '{1, 0, 1, 2'b00, 8'h00, 16'h0000};
      vecs[1]  = '{1, 0, 1, 2'b01, 8'h00, 16'h0000};
      vecs[2]  = '{1, 0, 1, 2'b11, 8'h00, 16'h0000};
      vecs[3]  = '{1, 0, 1, 2'b10, 8'h00, 16'h0002};
      vecs[4]  = '{1, 0, 0, 2'b10, 8'h00, 16'h0000};
      vecs[5]  = '{1, 0, 0, 2'b00, 8'h00, 16'h0000};
      vecs[6]  = '{0, 0, 1, 2'b10, 8'h00, 16'h0000};
      vecs[7]  = '{0, 1, 1, 2'b10, 8'hAB, 16'h0000};
      vecs[8]  = '{1, 0, 1, 2'b10, 8'h00, 16'h0002};
      vecs[9]  = '{0, 1, 1, 2'b01, 8'hCD, 16'h0000};
      vecs[10] = '{0, 1, 1, 2'b11, 8'hEF, 16'h0000};
      vecs[11] = '{0, 1, 0, 2'b00, 8'h12, 16'h0000};
      vecs[12] = '{1, 0, 1, 2'b10, 8'h00, 16'h0002};

      rst = 1; idle_bus();
      repeat (3) step();
      check("reset_tx", tx, 1);
      drive_status_read(); #1;
      check("reset_status", ioread_data, st(0, 1, 0, 0, 0));
      rst = 0; idle_bus();
      step();
      mon_en = 1;

      for (int i = 0; i < 13; i++) begin
         ioread = vecs[i].rd; iowrite = vecs[i].wr; uartctrl = vecs[i].cs;
         address = vecs[i].a; write_data = {24'h0, vecs[i].d};
         #1;
         check($sformatf("vec%0d_rdata", i), ioread_data, vecs[i].exp);
         check($sformatf("vec%0d_tx", i), tx, 1);
         step();
      end
      idle_bus();
      repeat (3) step();

      // Single 0x55 frame, cycle-exact waveform.
      w = cyc;
      drive_write(8'h55); sb.push_back(8'h55);
      step();
      drive_status_read();
      for (int off = 1; off <= 42; off++) begin
         check($sformatf("w55_tx_off%0d", off), tx, exp_tx(off, 8'h55));
         if (off == 1 || off == 42) check($sformatf("w55_busy_off%0d", off), ioread_data[0], 0);
         if (off == 2 || off == 41) check($sformatf("w55_busy_off%0d", off), ioread_data[0], 1);
         step();
      end
      idle_bus();
      wait_drain();

      // Back-to-back frames; three bytes queue behind the first.
      starts.delete();
      w = cyc;
      drive_write(8'h5A); sb.push_back(8'h5A); step();
      drive_write(8'hA3); sb.push_back(8'hA3); step();
      drive_write(8'h0F); sb.push_back(8'h0F); step();
      drive_write(8'hFF); sb.push_back(8'hFF); step();
      drive_status_read();
      step_to(w + 41); #1;
      check("b2b_count_pop1", ioread_data[10:8], 3);
      step_to(w + 81); #1;
      check("b2b_count_pop2", ioread_data[10:8], 2);
      step_to(w + 121); #1;
      check("b2b_count_pop3", ioread_data[10:8], 1);
      step(); #1;
      check("b2b_count_after", ioread_data[10:8], 0);
      idle_bus();
      wait_drain();
      check("b2b_frames", starts.size(), 4);
      if (starts.size() == 4) begin
         check("b2b_first_start", starts[0], w + 2);
         for (int i = 0; i < 3; i++)
            check($sformatf("b2b_gap%0d", i), starts[i + 1] - starts[i], 10 * CLK_DIV);
      end
      repeat (4) step();

      // Fill the FIFO, then overflow it.
      w = cyc;
      for (int i = 1; i <= 5; i++) begin
         drive_write(8'(i)); sb.push_back(8'(i)); step();
      end
      drive_status_read(); #1;
      check("fill_status", ioread_data, st(1, 0, 1, 0, 4));
      step();
      drive_write(8'h66); step();
      drive_status_read(); #1;
      check("ovf_status_set", ioread_data, st(1, 0, 1, 1, 4));
      step(); #1;
      check("ovf_status_clear", ioread_data, st(1, 0, 1, 0, 4));

      // Push while full in the same cycle as the end-of-stop pop.
      step_to(w + 40); #1;
      check("prepop_status", ioread_data, st(1, 0, 1, 0, 4));
      step();
      drive_write(8'hEE); step();
      drive_status_read(); #1;
      check("pop_push_status", ioread_data, st(1, 0, 0, 1, 3));
      step(); #1;
      check("pop_push_status2", ioread_data, st(1, 0, 0, 0, 3));
      idle_bus();
      wait_drain();

      // Reset in the middle of data bit 3, with a push in the reset cycle.
      mon_en = 0;
      w = cyc;
      drive_write(8'hC6); step();
      drive_write(8'h11); step();
      drive_write(8'h22); step();
      idle_bus();
      step_to(w + 2 + 17); #1;
      check("rst_pre_tx", tx, 0);
      rst = 1; drive_write(8'h77);
      step();
      rst = 0; drive_status_read(); #1;
      check("rst_tx", tx, 1);
      check("rst_status", ioread_data, st(0, 1, 0, 0, 0));
      idle_bus();
      seen_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx !== 1'b1) seen_low = 1'b1;
      end
      check("rst_no_frame", seen_low, 0);
      mon_en = 1;
      repeat (4) step();
      check("final_scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
